// File: rtl/imm_encoder.sv
// imm_encoder: packs an immediate and register fields into a 32-bit
// instruction word for the I/S/B/U/J formats, flags immediates that do
// not fit (range), odd branch/jump offsets (alignment) and unknown
// formats (source), and buffers {Instr, flags} in a 2-entry in-order FIFO.
module imm_encoder (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        InValid,
    output logic        InReady,
    input  logic [2:0]  ImmSrc,
    input  logic [63:0] Imm,
    input  logic [6:0]  Opcode,
    input  logic [4:0]  Rd,
    input  logic [4:0]  Rs1,
    input  logic [4:0]  Rs2,
    input  logic [2:0]  Funct3,
    output logic        OutValid,
    input  logic        OutReady,
    output logic [31:0] Instr,
    output logic        RangeErr,
    output logic        AlignErr,
    output logic        SrcErr,
    output logic [15:0] ErrCount
);

    localparam logic [2:0] SRC_I = 3'd0;
    localparam logic [2:0] SRC_S = 3'd1;
    localparam logic [2:0] SRC_B = 3'd2;
    localparam logic [2:0] SRC_U = 3'd3;
    localparam logic [2:0] SRC_J = 3'd4;

    localparam int DEPTH   = 2;
    localparam int ENTRY_W = 35;   // {SrcErr, AlignErr, RangeErr, Instr}

    // fits[k]: Imm equals the sign-extension of its low N bits, i.e. every
    // bit from N-1 upward is identical. N = 12, 13, 21, 32 for k = 0..3.
    logic [3:0] fits;

    for (genvar gi = 0; gi < 4; gi++) begin : g_fit
        localparam int N = (gi == 0) ? 12 : (gi == 1) ? 13 : (gi == 2) ? 21 : 32;
        assign fits[gi] = (&Imm[63:N-1]) | ~(|Imm[63:N-1]);
    end

    logic [31:0] enc_instr;
    logic        range_err;
    logic        align_err;
    logic        src_err;

    // Format-dependent bit placement and error detection; the truncated
    // encoding is emitted even when a range or alignment error is flagged.
    always_comb begin
        enc_instr = '0;
        range_err = 1'b0;
        align_err = 1'b0;
        src_err   = 1'b0;
        case (ImmSrc)
            SRC_I: begin
                enc_instr = {Imm[11:0], Rs1, Funct3, Rd, Opcode};
                range_err = ~fits[0];
            end
            SRC_S: begin
                enc_instr = {Imm[11:5], Rs2, Rs1, Funct3, Imm[4:0], Opcode};
                range_err = ~fits[0];
            end
            SRC_B: begin
                enc_instr = {Imm[12], Imm[10:5], Rs2, Rs1, Funct3, Imm[4:1], Imm[11], Opcode};
                range_err = ~fits[1];
                align_err = Imm[0];
            end
            SRC_U: begin
                enc_instr = {Imm[31:12], Rd, Opcode};
                range_err = ~fits[3] | (|Imm[11:0]);
            end
            SRC_J: begin
                enc_instr = {Imm[20], Imm[10:1], Imm[11], Imm[19:12], Rd, Opcode};
                range_err = ~fits[2];
                align_err = Imm[0];
            end
            default: begin
                src_err = 1'b1;
            end
        endcase
    end

    logic [ENTRY_W-1:0] entry_reg [DEPTH];
    logic [ENTRY_W-1:0] entry_next;
    logic [ENTRY_W-1:0] head;
    logic               wr_ptr_reg;
    logic               rd_ptr_reg;
    logic [1:0]         count_reg;
    logic [1:0]         count_next;
    logic [15:0]        err_count_reg;
    logic               push;
    logic               pop;
    logic               any_err;

    assign entry_next = {src_err, align_err, range_err, enc_instr};
    assign any_err    = range_err | align_err | src_err;

    // Ready depends only on occupancy before the edge, so a pop in the
    // same cycle never opens a slot for a push into a full FIFO.
    assign InReady  = rst_n & (count_reg != 2'd2);
    assign OutValid = (count_reg != 2'd0);
    assign push     = InValid & InReady;
    assign pop      = OutValid & OutReady;

    assign head     = entry_reg[rd_ptr_reg];
    assign Instr    = head[31:0];
    assign RangeErr = head[32];
    assign AlignErr = head[33];
    assign SrcErr   = head[34];
    assign ErrCount = err_count_reg;

    // Next occupancy from the push/pop pair.
    always_comb begin
        count_next = count_reg;
        case ({push, pop})
            2'b10:   count_next = count_reg + 2'd1;
            2'b01:   count_next = count_reg - 2'd1;
            default: count_next = count_reg;
        endcase
    end

    // Entry storage; cleared on reset so the head reads as zero afterwards.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                entry_reg[i] <= '0;
            end
        end else if (push) begin
            entry_reg[wr_ptr_reg] <= entry_next;
        end
    end

    // Pointers and occupancy; reset discards anything buffered.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_reg <= 1'b0;
            rd_ptr_reg <= 1'b0;
            count_reg  <= 2'd0;
        end else begin
            if (push) begin
                wr_ptr_reg <= ~wr_ptr_reg;
            end
            if (pop) begin
                rd_ptr_reg <= ~rd_ptr_reg;
            end
            count_reg <= count_next;
        end
    end

    // Saturating count of accepted requests carrying any error flag.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_count_reg <= '0;
        end else if (push && any_err && (err_count_reg != 16'hFFFF)) begin
            err_count_reg <= err_count_reg + 16'd1;
        end
    end

endmodule

// File: tb/tb_imm_encoder.sv
// Testbench for imm_encoder: directed format/error cases, backpressure,
// back-to-back throughput, reset mid-operation and a randomized run
// scored against a queue-based reference model.
module tb_imm_encoder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        InValid;
    logic        InReady;
    logic [2:0]  ImmSrc;
    logic [63:0] Imm;
    logic [6:0]  Opcode;
    logic [4:0]  Rd;
    logic [4:0]  Rs1;
    logic [4:0]  Rs2;
    logic [2:0]  Funct3;
    logic        OutValid;
    logic        OutReady;
    logic [31:0] Instr;
    logic        RangeErr;
    logic        AlignErr;
    logic        SrcErr;
    logic [15:0] ErrCount;

    int n_tests = 0;
    int n_fail  = 0;
    int err_exp = 0;

    typedef struct {
        logic [31:0] instr;
        logic        rng;
        logic        aln;
        logic        src;
        logic [63:0] imm;
        logic [2:0]  sel;
    } exp_t;

    exp_t q[$];

    imm_encoder dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .InValid  (InValid),
        .InReady  (InReady),
        .ImmSrc   (ImmSrc),
        .Imm      (Imm),
        .Opcode   (Opcode),
        .Rd       (Rd),
        .Rs1      (Rs1),
        .Rs2      (Rs2),
        .Funct3   (Funct3),
        .OutValid (OutValid),
        .OutReady (OutReady),
        .Instr    (Instr),
        .RangeErr (RangeErr),
        .AlignErr (AlignErr),
        .SrcErr   (SrcErr),
        .ErrCount (ErrCount)
    );

    always #5 clk = ~clk;

    // Reference encoding: fields shifted into place arithmetically, range
    // judged by signed comparison against +/- 2^(N-1).
    function automatic exp_t model(input logic [2:0] sel, input logic [63:0] imm,
                                   input logic [6:0] opc, input logic [4:0] rd,
                                   input logic [4:0] rs1, input logic [4:0] rs2,
                                   input logic [2:0] f3);
        exp_t e;
        longint s;
        longint hi;
        logic [63:0] w;
        int n;
        s = imm;
        w = 64'd0;
        n = 0;
        e.rng = 1'b0;
        e.aln = 1'b0;
        e.src = 1'b0;
        e.imm = imm;
        e.sel = sel;
        case (sel)
            3'd0: begin
                w = ((imm & 64'hFFF) << 20) | (64'(rs1) << 15) | (64'(f3) << 12)
                    | (64'(rd) << 7) | 64'(opc);
                n = 12;
            end
            3'd1: begin
                w = (((imm >> 5) & 64'h7F) << 25) | (64'(rs2) << 20) | (64'(rs1) << 15)
                    | (64'(f3) << 12) | ((imm & 64'h1F) << 7) | 64'(opc);
                n = 12;
            end
            3'd2: begin
                w = (((imm >> 12) & 64'h1) << 31) | (((imm >> 5) & 64'h3F) << 25)
                    | (64'(rs2) << 20) | (64'(rs1) << 15) | (64'(f3) << 12)
                    | (((imm >> 1) & 64'hF) << 8) | (((imm >> 11) & 64'h1) << 7) | 64'(opc);
                n = 13;
                e.aln = imm[0];
            end
            3'd3: begin
                w = (imm & 64'hFFFF_F000) | (64'(rd) << 7) | 64'(opc);
                n = 32;
                if ((imm & 64'hFFF) != 64'd0) e.rng = 1'b1;
            end
            3'd4: begin
                w = (((imm >> 20) & 64'h1) << 31) | (((imm >> 1) & 64'h3FF) << 21)
                    | (((imm >> 11) & 64'h1) << 20) | (((imm >> 12) & 64'hFF) << 12)
                    | (64'(rd) << 7) | 64'(opc);
                n = 21;
                e.aln = imm[0];
            end
            default: e.src = 1'b1;
        endcase
        if (n != 0) begin
            hi = longint'(1) <<< (n - 1);
            if (s < -hi || s >= hi) e.rng = 1'b1;
        end
        e.instr = w[31:0];
        return e;
    endfunction

    // Instruction-set style immediate decode, used for the round-trip check.
    function automatic logic [63:0] decode(input logic [31:0] ins, input logic [2:0] sel);
        logic [63:0] v;
        case (sel)
            3'd0: v = {{52{ins[31]}}, ins[31:20]};
            3'd1: v = {{52{ins[31]}}, ins[31:25], ins[11:7]};
            3'd2: v = {{51{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
            3'd3: v = {{32{ins[31]}}, ins[31:12], 12'h000};
            default: v = {{43{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
        endcase
        return v;
    endfunction

    // Random immediate: fully random, in range, or at the range boundary.
    function automatic logic [63:0] gen_imm(input logic [2:0] sel);
        int n;
        longint v;
        longint hi;
        n  = (sel == 3'd2) ? 13 : (sel == 3'd3) ? 32 : (sel == 3'd4) ? 21 : 12;
        hi = longint'(1) <<< (n - 1);
        case ($urandom_range(0, 3))
            0: v = longint'({$urandom, $urandom});
            1, 3: begin
                v = longint'({$urandom, $urandom});
                v = (v <<< (64 - n)) >>> (64 - n);
                if (sel == 3'd3) v = v & ~longint'(64'hFFF);
                if ($urandom_range(0, 1) == 1) v = v & ~longint'(1);
            end
            default: begin
                case ($urandom_range(0, 3))
                    0: v = hi - 1;
                    1: v = -hi;
                    2: v = hi;
                    default: v = -hi - 1;
                endcase
            end
        endcase
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic v, input logic [2:0] s, input logic [63:0] imm,
                           input logic [6:0] opc, input logic [4:0] rd, input logic [4:0] rs1,
                           input logic [4:0] rs2, input logic [2:0] f3);
        InValid = v;
        ImmSrc  = s;
        Imm     = imm;
        Opcode  = opc;
        Rd      = rd;
        Rs1     = rs1;
        Rs2     = rs2;
        Funct3  = f3;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) tick();
        n_tests++;
        if (InReady !== 1'b0 || OutValid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_hs: InReady=%b OutValid=%b required 0 0", InReady, OutValid);
        end
        n_tests++;
        if (Instr !== 32'h0 || {RangeErr, AlignErr, SrcErr} !== 3'b000 || ErrCount !== 16'h0) begin
            n_fail++;
            $display("FAIL reset_regs: Instr=%h flags=%b ErrCount=%h required 0 000 0",
                     Instr, {RangeErr, AlignErr, SrcErr}, ErrCount);
        end
        rst_n = 1'b1;
        #1;
        n_tests++;
        if (InReady !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_release: InReady=%b required 1", InReady);
        end
        q.delete();
        err_exp = 0;
        $display("[TB] reset done");
    endtask

    task automatic test_i_type();
        OutReady = 1'b1;
        set_req(1'b1, 3'd0, 64'hFFFF_FFFF_FFFF_FFFF, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0);
        tick();
        InValid = 1'b0;
        n_tests++;
        if (OutValid !== 1'b1 || Instr !== 32'hFFF00093 || {RangeErr, AlignErr, SrcErr} !== 3'b000) begin
            n_fail++;
            $display("FAIL i_type: OutValid=%b Instr=%h flags=%b required 1 fff00093 000",
                     OutValid, Instr, {RangeErr, AlignErr, SrcErr});
        end
        $display("[TB] i_type Instr=%h", Instr);
        tick();
        n_tests++;
        if (OutValid !== 1'b0) begin
            n_fail++;
            $display("FAIL i_type_pop: OutValid=%b required 0", OutValid);
        end
    endtask

    task automatic test_b_type();
        OutReady = 1'b1;
        set_req(1'b1, 3'd2, 64'd8, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0);
        tick();
        n_tests++;
        if (Instr !== 32'h00000463 || {RangeErr, AlignErr, SrcErr} !== 3'b000) begin
            n_fail++;
            $display("FAIL b_type: Instr=%h flags=%b required 00000463 000",
                     Instr, {RangeErr, AlignErr, SrcErr});
        end
        $display("[TB] b_type imm=8 Instr=%h", Instr);
        set_req(1'b1, 3'd2, 64'd3, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0);
        tick();
        InValid = 1'b0;
        err_exp++;
        n_tests++;
        if (Instr !== 32'h00000163 || AlignErr !== 1'b1 || RangeErr !== 1'b0 || ErrCount !== 16'd1) begin
            n_fail++;
            $display("FAIL b_align: Instr=%h AlignErr=%b RangeErr=%b ErrCount=%0d required 00000163 1 0 1",
                     Instr, AlignErr, RangeErr, ErrCount);
        end
        $display("[TB] b_type imm=3 Instr=%h AlignErr=%b", Instr, AlignErr);
        tick();
    endtask

    task automatic test_u_type();
        OutReady = 1'b1;
        set_req(1'b1, 3'd3, 64'h1234_5000, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0);
        tick();
        n_tests++;
        if (Instr !== 32'h123452B7 || {RangeErr, AlignErr, SrcErr} !== 3'b000) begin
            n_fail++;
            $display("FAIL u_type: Instr=%h flags=%b required 123452b7 000",
                     Instr, {RangeErr, AlignErr, SrcErr});
        end
        $display("[TB] u_type Instr=%h", Instr);
        set_req(1'b1, 3'd3, 64'h1234_5001, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0);
        tick();
        InValid = 1'b0;
        err_exp++;
        n_tests++;
        if (RangeErr !== 1'b1 || Instr !== 32'h123452B7 || ErrCount !== err_exp[15:0]) begin
            n_fail++;
            $display("FAIL u_range: RangeErr=%b Instr=%h ErrCount=%0d required 1 123452b7 %0d",
                     RangeErr, Instr, ErrCount, err_exp);
        end
        $display("[TB] u_type low bits set RangeErr=%b", RangeErr);
        tick();
    endtask

    task automatic test_i_range();
        OutReady = 1'b1;
        set_req(1'b1, 3'd0, 64'h800, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0);
        tick();
        err_exp++;
        n_tests++;
        if (RangeErr !== 1'b1 || Instr[31:20] !== 12'h800 || ErrCount !== err_exp[15:0]) begin
            n_fail++;
            $display("FAIL i_range: RangeErr=%b Instr[31:20]=%h ErrCount=%0d required 1 800 %0d",
                     RangeErr, Instr[31:20], ErrCount, err_exp);
        end
        $display("[TB] i_range Instr=%h RangeErr=%b", Instr, RangeErr);
        set_req(1'b1, 3'd7, 64'h801, 7'h13, 5'd1, 5'd2, 5'd3, 3'd4);
        tick();
        InValid = 1'b0;
        err_exp++;
        n_tests++;
        if (Instr !== 32'h0 || {RangeErr, AlignErr, SrcErr} !== 3'b001 || ErrCount !== err_exp[15:0]) begin
            n_fail++;
            $display("FAIL src_illegal: Instr=%h flags=%b ErrCount=%0d required 0 001 %0d",
                     Instr, {RangeErr, AlignErr, SrcErr}, ErrCount, err_exp);
        end
        $display("[TB] src=7 Instr=%h SrcErr=%b", Instr, SrcErr);
        tick();
    endtask

    task automatic test_backpressure();
        OutReady = 1'b0;
        set_req(1'b1, 3'd0, 64'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0);
        tick();
        set_req(1'b1, 3'd0, 64'd2, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0);
        n_tests++;
        if (InReady !== 1'b1 || OutValid !== 1'b1 || Instr !== 32'h00100093) begin
            n_fail++;
            $display("FAIL bp_first: InReady=%b OutValid=%b Instr=%h required 1 1 00100093",
                     InReady, OutValid, Instr);
        end
        tick();
        set_req(1'b1, 3'd0, 64'd3, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0);
        n_tests++;
        if (InReady !== 1'b0 || Instr !== 32'h00100093) begin
            n_fail++;
            $display("FAIL bp_full: InReady=%b Instr=%h required 0 00100093", InReady, Instr);
        end
        tick();
        n_tests++;
        if (InReady !== 1'b0 || OutValid !== 1'b1 || Instr !== 32'h00100093) begin
            n_fail++;
            $display("FAIL bp_hold: InReady=%b OutValid=%b Instr=%h required 0 1 00100093",
                     InReady, OutValid, Instr);
        end
        OutReady = 1'b1;
        tick();
        n_tests++;
        if (Instr !== 32'h00200093 || InReady !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_pop1: Instr=%h InReady=%b required 00200093 1", Instr, InReady);
        end
        tick();
        InValid = 1'b0;
        n_tests++;
        if (OutValid !== 1'b1 || Instr !== 32'h00300093) begin
            n_fail++;
            $display("FAIL bp_third: OutValid=%b Instr=%h required 1 00300093", OutValid, Instr);
        end
        tick();
        n_tests++;
        if (OutValid !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_drain: OutValid=%b required 0", OutValid);
        end
        $display("[TB] backpressure sequence done");
    endtask

    task automatic test_back_to_back();
        exp_t e;
        logic [2:0] sel;
        OutReady = 1'b1;
        for (int i = 0; i < 16; i++) begin
            sel = 3'($urandom_range(0, 4));
            set_req(1'b1, sel, gen_imm(sel), 7'($urandom), 5'($urandom), 5'($urandom),
                    5'($urandom), 3'($urandom));
            n_tests++;
            if (InReady !== 1'b1) begin
                n_fail++;
                $display("FAIL b2b_ready %0d: InReady=%b required 1", i, InReady);
            end
            if (i > 0) begin
                n_tests++;
                if (OutValid !== 1'b1 || Instr !== q[0].instr ||
                    {RangeErr, AlignErr, SrcErr} !== {q[0].rng, q[0].aln, q[0].src}) begin
                    n_fail++;
                    $display("FAIL b2b_data %0d: OutValid=%b Instr=%h flags=%b required 1 %h %b",
                             i, OutValid, Instr, {RangeErr, AlignErr, SrcErr},
                             q[0].instr, {q[0].rng, q[0].aln, q[0].src});
                end
                void'(q.pop_front());
            end
            e = model(ImmSrc, Imm, Opcode, Rd, Rs1, Rs2, Funct3);
            q.push_back(e);
            if ((e.rng | e.aln | e.src) && err_exp < 65535) err_exp++;
            $display("[TB] b2b push src=%0d imm=%h exp=%h", ImmSrc, Imm, e.instr);
            tick();
        end
        InValid = 1'b0;
        void'(q.pop_front());
        tick();
        n_tests++;
        if (OutValid !== 1'b0 || ErrCount !== err_exp[15:0]) begin
            n_fail++;
            $display("FAIL b2b_end: OutValid=%b ErrCount=%0d required 0 %0d", OutValid, ErrCount, err_exp);
        end
    endtask

    task automatic test_reset_mid();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        OutReady = 1'b1;
        for (int i = 0; i < 5; i++) begin
            set_req(1'b1, 3'd5, 64'($urandom), 7'h13, 5'd1, 5'd2, 5'd3, 3'd0);
            tick();
        end
        OutReady = 1'b0;
        set_req(1'b1, 3'd0, 64'd4, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0);
        tick();
        InValid = 1'b0;
        n_tests++;
        if (ErrCount !== 16'd5 || InReady !== 1'b0 || OutValid !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_full: ErrCount=%0d InReady=%b OutValid=%b required 5 0 1",
                     ErrCount, InReady, OutValid);
        end
        rst_n = 1'b0;
        #1;
        n_tests++;
        if (InReady !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_in_reset: InReady=%b required 0", InReady);
        end
        tick();
        rst_n = 1'b1;
        #1;
        n_tests++;
        if (OutValid !== 1'b0 || ErrCount !== 16'd0 || InReady !== 1'b1 || Instr !== 32'h0) begin
            n_fail++;
            $display("FAIL mid_after: OutValid=%b ErrCount=%0d InReady=%b Instr=%h required 0 0 1 0",
                     OutValid, ErrCount, InReady, Instr);
        end
        $display("[TB] reset mid-operation done");
        q.delete();
        err_exp = 0;
        tick();
    endtask

    task automatic test_random(input int cycles);
        exp_t e;
        logic [2:0] sel;
        bit acc;
        bit pop;
        for (int c = 0; c < cycles; c++) begin
            sel = 3'($urandom_range(0, 7));
            set_req($urandom_range(0, 3) != 0, sel, gen_imm(sel), 7'($urandom), 5'($urandom),
                    5'($urandom), 5'($urandom), 3'($urandom));
            OutReady = ($urandom_range(0, 4) < 3);
            #1;
            n_tests++;
            if (OutValid !== (q.size() != 0) || InReady !== (q.size() < 2)) begin
                n_fail++;
                $display("FAIL rand_hs cyc %0d: OutValid=%b InReady=%b required %b %b",
                         c, OutValid, InReady, q.size() != 0, q.size() < 2);
            end
            if (q.size() != 0) begin
                n_tests++;
                if (Instr !== q[0].instr ||
                    {RangeErr, AlignErr, SrcErr} !== {q[0].rng, q[0].aln, q[0].src}) begin
                    n_fail++;
                    $display("FAIL rand_data cyc %0d: Instr=%h flags=%b required %h %b",
                             c, Instr, {RangeErr, AlignErr, SrcErr},
                             q[0].instr, {q[0].rng, q[0].aln, q[0].src});
                end
                if (!(q[0].rng | q[0].aln | q[0].src)) begin
                    n_tests++;
                    if (decode(Instr, q[0].sel) !== q[0].imm) begin
                        n_fail++;
                        $display("FAIL rand_roundtrip cyc %0d: decoded=%h required %h",
                                 c, decode(Instr, q[0].sel), q[0].imm);
                    end
                end
            end
            n_tests++;
            if (ErrCount !== err_exp[15:0]) begin
                n_fail++;
                $display("FAIL rand_errcount cyc %0d: ErrCount=%0d required %0d", c, ErrCount, err_exp);
            end
            acc = InValid && (q.size() < 2);
            pop = (q.size() != 0) && OutReady;
            e = model(ImmSrc, Imm, Opcode, Rd, Rs1, Rs2, Funct3);
            if (pop) void'(q.pop_front());
            if (acc) begin
                q.push_back(e);
                if ((e.rng | e.aln | e.src) && err_exp < 65535) err_exp++;
                $display("[TB] rand push src=%0d imm=%h exp=%h flags=%b",
                         ImmSrc, Imm, e.instr, {e.rng, e.aln, e.src});
            end
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        rst_n    = 1'b0;
        OutReady = 1'b0;
        set_req(1'b0, 3'd0, 64'd0, 7'd0, 5'd0, 5'd0, 5'd0, 3'd0);
        test_reset();
        test_i_type();
        test_b_type();
        test_u_type();
        test_i_range();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        test_random(600);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/imm_encoder.md
IMM_ENCODER -- requirements
Module: imm_encoder

Interface
REQ-001 SHALL have no parameters; all widths fixed as listed.
REQ-002 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1: reset, synchronous, active-low.
REQ-004 SHALL have port InValid, input, 1: request valid.
REQ-005 SHALL have port InReady, output, 1: request accepted when InValid && InReady at a clk edge.
REQ-006 SHALL have port ImmSrc, input, 3: format select; 000 I, 001 S, 010 B, 011 U, 100 J, 101-111 illegal.
REQ-007 SHALL have port Imm, input, 64: byte-offset/value immediate, sign-extended as the datapath uses it.
REQ-008 SHALL have ports Opcode (input, 7), Rd (input, 5), Rs1 (input, 5), Rs2 (input, 5) and Funct3 (input, 3): instruction fields.
REQ-009 SHALL have port OutValid, output, 1: encoded instruction valid.
REQ-010 SHALL have port OutReady, input, 1: consumer takes the head entry when OutValid && OutReady.
REQ-011 SHALL have port Instr, output, 32: encoded instruction.
REQ-012 SHALL have ports RangeErr, AlignErr and SrcErr (each output, 1): per-entry error flags, qualified by OutValid.
REQ-013 SHALL have port ErrCount, output, 16: count of accepted requests with any error flag set.

Function
REQ-014 SHALL compute the encoding combinationally from inputs and store {Instr, flags} in a 2-entry in-order FIFO on acceptance.
REQ-015 SHALL drive InReady = (occupancy < 2); a pop in the same cycle does not permit a push when full.
REQ-016 SHALL present an accepted entry on Instr and OutValid on the cycle after acceptance when the FIFO was empty (latency 1).
REQ-017 SHALL sustain 1 request/cycle throughput when OutReady is held high.
REQ-018 SHALL hold Instr and all flags stable while OutValid && !OutReady.
REQ-019 SHALL, on simultaneous push and pop with occupancy 1, keep occupancy 1 and place the new entry at the head on the next cycle.
REQ-020 SHALL encode I format as Instr = {Imm[11:0], Rs1, Funct3, Rd, Opcode}.
REQ-021 SHALL encode S format as Instr = {Imm[11:5], Rs2, Rs1, Funct3, Imm[4:0], Opcode}.
REQ-022 SHALL encode B format as Instr = {Imm[12], Imm[10:5], Rs2, Rs1, Funct3, Imm[4:1], Imm[11], Opcode}.
REQ-023 SHALL encode U format as Instr = {Imm[31:12], Rd, Opcode}.
REQ-024 SHALL encode J format as Instr = {Imm[20], Imm[10:1], Imm[11], Imm[19:12], Rd, Opcode}.
REQ-025 SHALL, for ImmSrc 101-111, set Instr = 0 and SrcErr = 1, with RangeErr = 0 and AlignErr = 0.
REQ-026 SHALL set RangeErr when Imm differs from the sign-extension of its low N bits: N = 12 for I and S, 13 for B, 32 for U, 21 for J.
REQ-027 SHALL additionally set RangeErr for U format when Imm[11:0] != 0.
REQ-028 SHALL set AlignErr for B or J format when Imm[0] = 1.
REQ-029 SHALL still emit the truncated encoding on RangeErr or AlignErr.
REQ-030 SHALL guarantee round trip: with no flag set, decoding Instr with the same ImmSrc returns Imm exactly.
REQ-031 SHALL increment ErrCount by 1 on each accepted request with any flag set, saturating at 0xFFFF.

Reset
REQ-032 SHALL, while rst_n = 0 at a clk edge, empty the FIFO and clear ErrCount, Instr, RangeErr, AlignErr and SrcErr to 0, with OutValid = 0.
REQ-033 SHALL hold InReady = 0 while rst_n = 0 and drive InReady = 1 on the first cycle after release.
REQ-034 SHALL discard all buffered entries on reset mid-operation; no partial entry survives.

Verification
REQ-035 SHALL pass I-type: ImmSrc=000, Imm=0xFFFF_FFFF_FFFF_FFFF, Opcode=0x13, Rd=1, Rs1=0, Funct3=0 -> next cycle Instr=0xFFF00093, all flags 0.
REQ-036 SHALL pass B-type: ImmSrc=010, Imm=8, Opcode=0x63, Rs1=Rs2=0, Funct3=0 -> Instr=0x00000463; repeating with Imm=3 -> AlignErr=1 and ErrCount=1.
REQ-037 SHALL pass U-type: ImmSrc=011, Imm=0x12345000, Rd=5, Opcode=0x37 -> Instr=0x123452B7; repeating with Imm=0x12345001 -> RangeErr=1.
REQ-038 SHALL pass I-type range check: Imm=0x800 -> RangeErr=1, Instr[31:20]=0x800; ImmSrc=111 -> Instr=0, SrcErr=1.
REQ-039 SHALL pass backpressure: OutReady=0 with 3 back-to-back requests -> InReady=0 after 2 accepts; then OutReady=1 -> entries emerge in order, third accepted the cycle after the first pop.
REQ-040 SHALL pass reset mid-operation: FIFO full with ErrCount=5, rst_n=0 for 1 cycle -> OutValid=0, ErrCount=0, InReady=1 on the next cycle.
